// File: rtl/instruction_fetch_if.sv
// Bus between the instruction-fetch stage and its controller: hazard/branch
// controls, the program-load side port and the IF/ID outputs.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  i_enable;
    logic                  i_PCWrite;
    logic                  i_if_id_write;
    logic                  i_PCSrc;
    logic [31:0]           i_branch_target;
    logic                  i_load_en;
    logic [ADDR_WIDTH-1:0] i_load_addr;
    logic [31:0]           i_load_data;
    logic [31:0]           o_instruction;
    logic [31:0]           o_pc_next;
    logic [31:0]           o_pc;
    logic                  o_halt;

    modport master (
        output i_enable, i_PCWrite, i_if_id_write, i_PCSrc, i_branch_target,
        output i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_pc_next, o_pc, o_halt
    );

    modport slave (
        input  i_enable, i_PCWrite, i_if_id_write, i_PCSrc, i_branch_target,
        input  i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_pc_next, o_pc, o_halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC, word-addressed program memory and the
// IF/ID register, with stall, branch flush, halt and debug program loading.
module instruction_fetch #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {RUN, HALTED} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcNext_q, pcNext_d;
    logic [31:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] fetchIndex;
    logic [31:0]           fetchWord;
    logic [31:0]           pcPlus4;

    assign fetchIndex = pc_q[ADDR_WIDTH+1:2];
    assign fetchWord  = mem_q[fetchIndex];
    assign pcPlus4    = pc_q + 32'd4;

    // Program memory survives reset; only the debug load port writes it.
    always_ff @(posedge clk) begin
        if (!rst && bus.i_load_en) begin
            mem_q[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcNext_d = pcNext_q;

        if (bus.i_load_en || !bus.i_enable || state_q == HALTED) begin
            // fetch suppressed: everything holds
        end else if (bus.i_PCSrc) begin
            pc_d     = bus.i_branch_target;
            instr_d  = 32'd0;
            pcNext_d = 32'd0;
        end else if (fetchWord == HALT_WORD) begin
            state_d  = HALTED;
            instr_d  = 32'd0;
            pcNext_d = pcPlus4;
        end else begin
            if (bus.i_PCWrite) begin
                pc_d = pcPlus4;
            end
            if (bus.i_if_id_write) begin
                instr_d  = fetchWord;
                pcNext_d = pcPlus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= 32'd0;
            instr_q  <= 32'd0;
            pcNext_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcNext_q <= pcNext_d;
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pc_next     = pcNext_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_halt        = (state_q == HALTED);
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the instruction decoder. Holds the program counter and a word-addressed instruction memory, and drives the IF/ID pipeline register (instruction, PC+4) consumed by the decoder. Obeys the decoder's hazard outputs (PCWrite, if_id_write), redirects on taken branches with a one-slot flush, and stops on a halt word. Program memory is loaded through a side port by the debug unit.

## Interface
- ADDR_WIDTH, 8: instruction memory index width; depth = 2**ADDR_WIDTH words of 32 bits
- HALT_WORD, 32'hFFFFFFFF: instruction encoding that halts fetch
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance enable (debug run/step); 0 freezes all stage state
- i_PCWrite  in  1  from hazard logic; 0 holds PC (load-use stall)
- i_if_id_write  in  1  from hazard logic; 0 holds IF/ID register
- i_PCSrc  in  1  branch taken
- i_branch_target  in  32  byte address of branch destination
- i_load_en  in  1  program-load write strobe
- i_load_addr  in  ADDR_WIDTH  word index to write
- i_load_data  in  32  instruction word to write
- o_instruction  out  32  IF/ID instruction
- o_pc_next  out  32  IF/ID PC+4
- o_pc  out  32  current PC register (debug visibility)
- o_halt  out  1  sticky halt flag

## Operation
- Memory index = PC[ADDR_WIDTH+1:2]; PC[1:0] ignored; addresses wrap modulo depth. Read combinational; write synchronous.
- Memory contents are NOT affected by rst.
- Per rising edge, priority order:
  1. rst=1: PC<=0, o_instruction<=0, o_pc_next<=0, o_halt<=0.
  2. i_load_en=1: mem[i_load_addr]<=i_load_data; PC, IF/ID, o_halt hold (fetch suppressed).
  3. i_enable=0 or o_halt=1: all state holds.
  4. i_PCSrc=1: PC<=i_branch_target; o_instruction<=0 (NOP), o_pc_next<=0. Overrides i_PCWrite/i_if_id_write and halt detection.
  5. fetched word == HALT_WORD: PC holds; o_halt<=1; o_instruction<=0; o_pc_next<=PC+4.
  6. normal: if i_PCWrite then PC<=PC+4 else PC holds; if i_if_id_write then o_instruction<=mem[index], o_pc_next<=PC+4 else IF/ID holds.
- PC+4 is 32-bit modular: 32'hFFFFFFFC+4 = 0.
- State: RUN / HALTED (o_halt). RUN->HALTED on rule 5; HALTED->RUN only via rst.

## Timing
- Reset values: o_pc=0, o_instruction=0, o_pc_next=0, o_halt=0.
- Fetch latency 1 cycle: word at PC appears on o_instruction after the edge that samples it; o_pc advances on the same edge.
- Branch: i_PCSrc sampled at edge N; o_pc=target after N; o_instruction=0 after N; target's word on o_instruction after N+1.
- Stall (i_PCWrite=0, i_if_id_write=0): both hold exactly; no instruction lost or duplicated on release.
- Load write visible to a fetch on the next edge after the write edge.
- Reset mid-operation (including while halted or stalled) takes effect on that edge regardless of other inputs.

## Test plan
- Load mem[0..3]=0x20010005,0x20020007,0x00221820,0xFFFFFFFF, rst then run -> o_instruction sequence 0x20010005,0x20020007,0x00221820,0x00000000 with o_pc_next 4,8,12,16; o_halt=1 after 4th edge, o_pc stays 12.
- Stall: i_PCWrite=i_if_id_write=0 for 2 cycles at PC=4 -> o_pc=4, o_instruction=mem[0] held; on release mem[1] then mem[2] follow, none skipped.
- Branch: at PC=8 assert i_PCSrc with target 0x20 for one cycle -> o_pc=0x20, o_instruction=0; next edge o_instruction=mem[8], o_pc=0x24.
- i_enable=0 for 3 cycles mid-program -> o_pc, o_instruction, o_pc_next unchanged; resumes exactly.
- Reset while halted -> o_halt=0, o_pc=0, o_instruction=0; memory contents still present (re-run reproduces scenario 1).
- Wrap: branch to 0xFFFFFFFC (ADDR_WIDTH=8, mem[255]=0x11111111) -> o_instruction=0x11111111, o_pc_next=0, o_pc=0.
